psram_ctrl: RTL and testbench

Synchronous controller that turns 32-bit word requests from the memory-space decoder into 16-bit asynchronous PSRAM cycles on the Blue Whale board pins (`psram_*`). It sits directly downstream of `mem_space` and drives the same pin set that `sim_psram` models in simulation. Each request is split into a low and a high half-word access, with configurable access and recovery timing in clock cycles.

---
 rtl/psram_ctrl_if.sv | 14 +
 rtl/psram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_psram_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/psram_ctrl_if.sv
// Host-side word request bus between mem_space and psram_ctrl.
interface psram_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [22:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        busy_o;

  modport master (output req_i, we_i, addr_i, be_i, data_i, input  data_o, ack_o, busy_o);
  modport slave  (input  req_i, we_i, addr_i, be_i, data_i, output data_o, ack_o, busy_o);
endinterface

// File: rtl/psram_ctrl.sv
// Splits 32-bit word requests into two 16-bit async PSRAM half-word cycles.
// Optional PSRAM_PAGE_MODE_EN: reads keep CE# low and fetch the high half in-page.
module psram_ctrl #(
  parameter int ACCESS_CYCLES   = 4,
  parameter int PAGE_CYCLES     = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  psram_ctrl_if.slave bus,
  output logic        psram_cen,
  output logic        psram_wen,
  output logic        psram_oen,
  output logic        psram_lbn,
  output logic        psram_ubn,
  output logic [21:0] psram_a,
  inout  wire  [15:0] psram_d
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_REC  = 3'd4;

  localparam logic [3:0] ACC_L  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] PAGE_L = 4'(PAGE_CYCLES - 1);
  localparam logic [3:0] REC_L  = 4'(RECOVERY_CYCLES - 1);

`ifdef PSRAM_PAGE_MODE_EN
  localparam bit PAGE_EN = 1'b1;
`else
  localparam bit PAGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic cen, wen, oen, lbn, ubn, doe;
  } pins_t;

  localparam pins_t IDLE_PINS = '{cen:1'b1, wen:1'b1, oen:1'b1, lbn:1'b1, ubn:1'b1, doe:1'b0};

  // Control pin set for the first cycle of a half access.
  function automatic pins_t acc_pins(input logic we, input logic [1:0] be2);
    acc_pins = '{cen:1'b0, wen:~we, oen:we,
                 lbn:we ? ~be2[0] : 1'b0, ubn:we ? ~be2[1] : 1'b0, doe:we};
  endfunction

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [20:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [15:0] rd_lo;
  logic [15:0] d_out;
  pins_t       pins;
  logic        unused_addr;

  assign unused_addr = ^bus.addr_i[1:0];

  assign psram_cen = pins.cen;
  assign psram_wen = pins.wen;
  assign psram_oen = pins.oen;
  assign psram_lbn = pins.lbn;
  assign psram_ubn = pins.ubn;
  assign psram_d   = pins.doe ? d_out : 16'hzzzz;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
      rd_lo      <= '0;
      d_out      <= '0;
      pins       <= IDLE_PINS;
      psram_a    <= '0;
      bus.ack_o  <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.ack_o <= 1'b0;
      case (state)
        S_IDLE, S_REC: begin
          if (state == S_REC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) bus.busy_o <= 1'b0;
          end else if (bus.req_i && !bus.busy_o) begin
            we_q       <= bus.we_i;
            addr_q     <= bus.addr_i[22:2];
            be_q       <= bus.be_i;
            wd_q       <= bus.data_i;
            bus.busy_o <= 1'b1;
            if (!bus.we_i || bus.be_i[1:0] != 2'b00) begin
              state   <= S_LO;
              cnt     <= ACC_L;
              pins    <= acc_pins(bus.we_i, bus.be_i[1:0]);
              psram_a <= {bus.addr_i[22:2], 1'b0};
              d_out   <= bus.data_i[15:0];
            end else if (bus.be_i[3:2] != 2'b00) begin
              state   <= S_HI;
              cnt     <= ACC_L;
              pins    <= acc_pins(1'b1, bus.be_i[3:2]);
              psram_a <= {bus.addr_i[22:2], 1'b1};
              d_out   <= bus.data_i[31:16];
            end else begin
              // Empty write: one silent cycle in HI so the ack lands on the next edge.
              state <= S_HI;
              cnt   <= 4'd0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_LO: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (we_q && cnt == 4'd1) pins.wen <= 1'b1;
          end else begin
            rd_lo <= psram_d;
            if (PAGE_EN && !we_q) begin
              state      <= S_HI;
              cnt        <= PAGE_L;
              psram_a[0] <= 1'b1;
            end else if (we_q && be_q[3:2] == 2'b00) begin
              state      <= S_REC;
              cnt        <= REC_L;
              pins       <= IDLE_PINS;
              bus.ack_o  <= 1'b1;
              bus.busy_o <= (REC_L != 4'd0);
            end else begin
              state <= S_GAP;
              cnt   <= REC_L;
              pins  <= IDLE_PINS;
            end
          end
        end
        S_GAP: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= S_HI;
            cnt     <= ACC_L;
            pins    <= acc_pins(we_q, be_q[3:2]);
            psram_a <= {addr_q, 1'b1};
            d_out   <= wd_q[31:16];
          end
        end
        S_HI: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (we_q && cnt == 4'd1) pins.wen <= 1'b1;
          end else begin
            if (!we_q) bus.data_o <= {psram_d, rd_lo};
            state      <= S_REC;
            cnt        <= REC_L;
            pins       <= IDLE_PINS;
            bus.ack_o  <= 1'b1;
            bus.busy_o <= (REC_L != 4'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psram_ctrl.sv
// Randomized bench for psram_ctrl with a pin-level PSRAM model and a word-level reference memory.
module tb_psram_ctrl;
  localparam int A = 4;
  localparam int P = 2;
  localparam int R = 1;
`ifdef PSRAM_PAGE_MODE_EN
  localparam bit PAGE = 1'b1;
`else
  localparam bit PAGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_ctrl_if bus();
  logic        cen, wen, oen, lbn, ubn;
  logic [21:0] pa;
  wire  [15:0] pd;

  psram_ctrl #(.ACCESS_CYCLES(A), .PAGE_CYCLES(P), .RECOVERY_CYCLES(R)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .psram_cen(cen), .psram_wen(wen), .psram_oen(oen), .psram_lbn(lbn), .psram_ubn(ubn),
    .psram_a(pa), .psram_d(pd)
  );

  // Pin-level PSRAM model (low 4K half-words) and word-level reference memory.
  logic [15:0] pmem    [0:4095];
  logic [31:0] ref_mem [0:2047];
  assign pd = (!cen && !oen && wen) ? pmem[pa[11:0]] : 16'hzzzz;

  int          ce_low = 0;
  int          ce_fall = 0;
  logic        ce_prev = 1'b1;
  logic [21:0] last_a = '0;
  logic        last_lbn = 1'b1, last_ubn = 1'b1;

  always @(negedge clk) begin
    if (!cen) ce_low++;
    if (!cen && ce_prev) ce_fall++;
    ce_prev = cen;
    if (!cen && !wen) begin
      if (!lbn) pmem[pa[11:0]][7:0]  = pd[7:0];
      if (!ubn) pmem[pa[11:0]][15:8] = pd[15:8];
      last_a = pa; last_lbn = lbn; last_ubn = ubn;
    end
  end

  int checks = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic we, input logic [3:0] be);
    if (!we) return PAGE ? A + P : 2 * A + R;
    if (be == 4'h0) return 1;
    if (be[1:0] != 2'b00 && be[3:2] != 2'b00) return 2 * A + R;
    return A;
  endfunction

  function automatic int exp_halves(input logic we, input logic [3:0] be);
    if (!we) return PAGE ? 1 : 2;
    return int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00);
  endfunction

  task automatic ref_write(input logic [22:0] addr, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr[12:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_req(input logic we, input logic [22:0] addr, input logic [3:0] be,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata,
                        output int cel, output int cef);
    int w, c0, f0;
    w = 0;
    @(negedge clk);
    while (bus.busy_o && w < 50) begin @(negedge clk); w++; end
    chk("idle_wait", 32'(bus.busy_o), 32'h0);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.be_i = be; bus.data_i = d;
    c0 = ce_low; f0 = ce_fall;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    lat = 0;
    while (!bus.ack_o && lat < 100) begin @(posedge clk); #1; lat++; end
    rdata = bus.data_o;
    cel = ce_low - c0;
    cef = ce_fall - f0;
    @(posedge clk); #1;
    chk("ack_width", 32'(bus.ack_o), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cel, cef, k;
    logic [31:0] rd;
    logic        we;
    logic [22:0] addr;
    logic [3:0]  be;
    logic [31:0] d;

    for (int i = 0; i < 4096; i++) pmem[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.data_i = '0;

    #12;
    chk("rst_pins", 32'({cen, wen, oen, lbn, ubn}), 32'h1f);
    chk("rst_a", 32'(pa), 32'h0);
    chk("rst_ack_busy", 32'({bus.ack_o, bus.busy_o}), 32'h0);
    chk("rst_data", bus.data_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Full write then read-back
    do_req(1'b1, 23'h000100, 4'hF, 32'hDEADBEEF, lat, rd, cel, cef);
    ref_write(23'h000100, 4'hF, 32'hDEADBEEF);
    chk("wr_lat", 32'(lat), 32'd9);
    chk("wr_lo_half", 32'(pmem[12'h080]), 32'h0000BEEF);
    chk("wr_hi_half", 32'(pmem[12'h081]), 32'h0000DEAD);
    chk("wr_ce_falls", 32'(cef), 32'd2);

    do_req(1'b0, 23'h000100, 4'h0, 32'h0, lat, rd, cel, cef);
    chk("rd_lat", 32'(lat), 32'(exp_lat(1'b0, 4'h0)));
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_ce_low", 32'(cel), PAGE ? 32'd6 : 32'd8);

    // Partial write into the high half only
    do_req(1'b1, 23'h000200, 4'hF, 32'h11223344, lat, rd, cel, cef);
    ref_write(23'h000200, 4'hF, 32'h11223344);
    do_req(1'b1, 23'h000200, 4'b0100, 32'h00AA0000, lat, rd, cel, cef);
    ref_write(23'h000200, 4'b0100, 32'h00AA0000);
    chk("pw_lat", 32'(lat), 32'd4);
    chk("pw_ce_falls", 32'(cef), 32'd1);
    chk("pw_lb_ub", 32'({last_lbn, last_ubn}), 32'h1);
    chk("pw_addr", 32'(last_a), 32'h101);
    do_req(1'b0, 23'h000200, 4'h0, 32'h0, lat, rd, cel, cef);
    chk("pw_readback", rd, 32'h11AA3344);

    // Write with no byte enables
    do_req(1'b1, 23'h000300, 4'h0, 32'hFFFFFFFF, lat, rd, cel, cef);
    chk("be0_lat", 32'(lat), 32'd1);
    chk("be0_ce_low", 32'(cel), 32'd0);

    // Back-to-back with req held high
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 23'h000100; bus.be_i = 4'h0;
    @(posedge clk); #1;
    k = 0;
    while (!bus.ack_o && k < 100) begin @(posedge clk); #1; k++; end
    chk("b2b_lat1", 32'(k), 32'(exp_lat(1'b0, 4'h0)));
    chk("b2b_ce_high", 32'(cen), 32'h1);
    repeat (R) @(posedge clk);
    #1;
    chk("b2b_accept", 32'({bus.busy_o, cen}), 32'h2);
    bus.req_i = 1'b0;
    k = 0;
    while (!bus.ack_o && k < 100) begin @(posedge clk); #1; k++; end
    chk("b2b_lat2", 32'(k), 32'(exp_lat(1'b0, 4'h0)));
    chk("b2b_data", bus.data_o, 32'hDEADBEEF);

    // Reset two cycles into the low half of a read
    @(negedge clk);
    while (bus.busy_o) @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 23'h000200;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_pins", 32'({cen, wen, oen, lbn, ubn}), 32'h1f);
    chk("mr_a", 32'(pa), 32'h0);
    chk("mr_busy_ack", 32'({bus.busy_o, bus.ack_o}), 32'h0);
    chk("mr_data", bus.data_o, 32'h0);
    k = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.ack_o) k++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (bus.ack_o) k++; end
    chk("mr_no_ack", 32'(k), 32'h0);
    do_req(1'b0, 23'h000200, 4'h0, 32'h0, lat, rd, cel, cef);
    chk("mr_read_lat", 32'(lat), 32'(exp_lat(1'b0, 4'h0)));
    chk("mr_read_data", rd, 32'h11AA3344);

    // Random traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = {13'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      be   = 4'($urandom_range(0, 15));
      d    = $urandom;
      do_req(we, addr, be, d, lat, rd, cel, cef);
      chk("rnd_lat", 32'(lat), 32'(exp_lat(we, be)));
      chk("rnd_halves", 32'(cef), 32'(exp_halves(we, be)));
      if (we) ref_write(addr, be, d);
      else    chk("rnd_rdata", rd, ref_mem[addr[12:2]]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
